// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the ReLU + 2x2 max-pool stage.
// Imported by the pooling top and its running-max unit.
package pool_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } pool_state_t;

  function automatic int data_size(
    input int in_size,
    input int carry_size
  );
    return 2 * in_size + carry_size;
  endfunction

  function automatic int pool_dim(input int c);
    return c / 2;
  endfunction

endpackage

// File: rtl/pool_max_unit.sv
// Signed running-max accumulator: clear, then fold in each enabled sample.
// o_max already includes the sample presented in an enabled cycle.
module pool_max_unit #(
  parameter int D = 20
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_en,
  input  logic signed [D-1:0] i_data,
  output logic signed [D-1:0] o_max
);

  logic signed [D-1:0] r_max;
  logic signed [D-1:0] w_cand;

  assign w_cand = (i_data > r_max) ? i_data : r_max;
  assign o_max  = i_en ? w_cand : r_max;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_max <= '0;
    end else if (i_clear) begin
      r_max <= '0;
    end else if (i_en) begin
      r_max <= w_cand;
    end
  end

endmodule

// File: rtl/max_pool_relu.sv
// ReLU + 2x2 stride-2 max pooling from the ofmap memory into the pool memory.
// One read outstanding at a time, so any read latency is tolerated.
module max_pool_relu
  import pool_pkg::*;
#(
  parameter int N_FILTER       = 16,
  parameter int CONVS_PER_LINE = 15,
  parameter int MEM_SIZE       = 12,
  parameter int INPUT_SIZE     = 8,
  parameter int CARRY_SIZE     = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_pool,
  output logic                end_pool,
  output logic                ofmap_ce,
  output logic [MEM_SIZE-1:0] ofmap_address,
  input  logic                ofmap_valid,
  input  logic signed [data_size(INPUT_SIZE, CARRY_SIZE)-1:0] ofmap_value,
  output logic                pool_ce,
  output logic                pool_we,
  output logic [MEM_SIZE-1:0] pool_address,
  output logic signed [data_size(INPUT_SIZE, CARRY_SIZE)-1:0] pool_value
);

  localparam int D  = data_size(INPUT_SIZE, CARRY_SIZE);
  localparam int C  = CONVS_PER_LINE;
  localparam int P  = pool_dim(C);
  localparam int FW = (N_FILTER > 1) ? $clog2(N_FILTER) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  pool_state_t r_state, w_state_n;
  logic [FW-1:0] r_f, w_f_n;
  logic [PW-1:0] r_pr, w_pr_n;
  logic [PW-1:0] r_pc, w_pc_n;
  logic [1:0]    r_q, w_q_n;
  logic          w_last;

  logic                r_end_pool;
  logic                r_ofmap_ce;
  logic [MEM_SIZE-1:0] r_ofmap_address;
  logic                r_pool_ce;
  logic [MEM_SIZE-1:0] r_pool_address;
  logic signed [D-1:0] r_pool_value;

  logic [MEM_SIZE-1:0] w_rd_addr;
  logic [MEM_SIZE-1:0] w_pool_addr;
  logic                w_clear;
  logic                w_capture;
  logic signed [D-1:0] w_max;

  assign w_last = (r_f == FW'(N_FILTER - 1))
               && (r_pr == PW'(P - 1))
               && (r_pc == PW'(P - 1));

  always_comb begin
    w_state_n = r_state;
    w_f_n     = r_f;
    w_pr_n    = r_pr;
    w_pc_n    = r_pc;
    w_q_n     = r_q;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_pool) begin
          w_state_n = ST_READ;
          w_f_n     = '0;
          w_pr_n    = '0;
          w_pc_n    = '0;
          w_q_n     = '0;
        end
      end
      ST_READ: w_state_n = ST_WAIT;
      ST_WAIT: begin
        if (ofmap_valid) begin
          if (r_q == 2'd3) begin
            w_state_n = ST_WRITE;
            w_q_n     = 2'd0;
          end else begin
            w_state_n = ST_READ;
            w_q_n     = r_q + 2'd1;
          end
        end
      end
      ST_WRITE: begin
        if (w_last) begin
          w_state_n = ST_DONE;
          w_f_n     = '0;
          w_pr_n    = '0;
          w_pc_n    = '0;
        end else begin
          w_state_n = ST_READ;
          if (r_pc == PW'(P - 1)) begin
            w_pc_n = '0;
            if (r_pr == PW'(P - 1)) begin
              w_pr_n = '0;
              w_f_n  = r_f + FW'(1);
            end else begin
              w_pr_n = r_pr + PW'(1);
            end
          end else begin
            w_pc_n = r_pc + PW'(1);
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Address of the quadrant about to be read; odd last row/col never reached.
  assign w_rd_addr = MEM_SIZE'(int'(w_f_n) * C * C
                   + (2 * int'(w_pr_n) + int'(w_q_n[1])) * C
                   + 2 * int'(w_pc_n) + int'(w_q_n[0]));

  assign w_pool_addr = MEM_SIZE'(int'(r_f) * P * P
                     + int'(r_pr) * P + int'(r_pc));

  assign w_clear   = (r_state == ST_READ) && (r_q == 2'd0);
  assign w_capture = (r_state == ST_WAIT) && ofmap_valid;

  pool_max_unit #(
    .D(D)
  ) u_max (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_clear(w_clear),
    .i_en   (w_capture),
    .i_data (ofmap_value),
    .o_max  (w_max)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_f             <= '0;
      r_pr            <= '0;
      r_pc            <= '0;
      r_q             <= '0;
      r_end_pool      <= 1'b0;
      r_ofmap_ce      <= 1'b0;
      r_ofmap_address <= '0;
      r_pool_ce       <= 1'b0;
      r_pool_address  <= '0;
      r_pool_value    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_f        <= w_f_n;
      r_pr       <= w_pr_n;
      r_pc       <= w_pc_n;
      r_q        <= w_q_n;
      r_end_pool <= (w_state_n == ST_DONE);
      r_ofmap_ce <= (w_state_n == ST_READ);
      r_pool_ce  <= (w_state_n == ST_WRITE);
      if (w_state_n == ST_READ) begin
        r_ofmap_address <= w_rd_addr;
      end
      if (w_state_n == ST_WRITE) begin
        r_pool_address <= w_pool_addr;
        r_pool_value   <= w_max;
      end
    end
  end

  assign end_pool      = r_end_pool;
  assign ofmap_ce      = r_ofmap_ce;
  assign ofmap_address = r_ofmap_address;
  assign pool_ce       = r_pool_ce;
  assign pool_we       = r_pool_ce;
  assign pool_address  = r_pool_address;
  assign pool_value    = r_pool_value;

endmodule
